// File: rtl/smart_bulb_pkg.sv
// ============================================================================
// Module   : smart_bulb_pkg
// Brief    : Shared types, constants and colour-mask helper for smart_bulb_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package smart_bulb_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_RAMP_DN = 2'd2,
        ST_STEADY  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WHITE = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2,
        GREEN = 2'd3
    } color_t;

    typedef struct packed {
        logic       on_off;
        logic [3:0] brightness;
        color_t     color;
    } cmd_t;

    localparam logic [3:0] LVL_MAX = 4'd15;

    // Returned as {r, g, b}
    function automatic logic [2:0] color_mask(input color_t c);
        logic [2:0] m;
        case (c)
            WHITE:   m = 3'b111;
            RED:     m = 3'b100;
            BLUE:    m = 3'b001;
            GREEN:   m = 3'b010;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bulb_pwm.sv
// ============================================================================
// Module   : bulb_pwm
// Brief    : 16-step PWM generator with per-colour channel masking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bulb_pwm
    import smart_bulb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] level,
    input  color_t     color,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b
);

    logic [3:0] pwm_cnt;
    logic       duty;
    logic [2:0] mask;

    assign duty = (level > pwm_cnt);
    assign mask = color_mask(color);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 4'd0;
            pwm_r   <= 1'b0;
            pwm_g   <= 1'b0;
            pwm_b   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            pwm_r   <= duty & mask[2];
            pwm_g   <= duty & mask[1];
            pwm_b   <= duty & mask[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/smart_bulb_ctrl.sv
// ============================================================================
// Module   : smart_bulb_ctrl
// Brief    : Bulb-end controller: input capture, brightness ramp FSM, PWM out.
//            Fade ramping is built only when SMART_BULB_FADE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module smart_bulb_ctrl
    import smart_bulb_pkg::*;
#(
    parameter int FADE_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on_off,
    input  logic [3:0]       brightness,
    input  logic [1:0]       color,
    output logic             pwm_r,
    output logic             pwm_g,
    output logic             pwm_b,
    output logic [3:0]       level,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_cnt
);

    if (FADE_DIV < 1 || FADE_DIV > 255) begin : g_fade_div_range
        $error("smart_bulb_ctrl: FADE_DIV must be within 1..255");
    end

    cmd_t       cmd_now;
    cmd_t       in_q;
    logic       armed;
    logic [3:0] target;
    state_t     state;

    assign cmd_now = cmd_t'({on_off, brightness, color});
    assign target  = in_q.on_off ? in_q.brightness : 4'd0;

    // armed suppresses counting on the first capture after reset release
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= '0;
            armed   <= 1'b0;
            cmd_cnt <= '0;
        end else begin
            in_q  <= cmd_now;
            armed <= 1'b1;
            if (armed && (cmd_now != in_q)) begin
                cmd_cnt <= cmd_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SMART_BULB_FADE_EN
    localparam logic [7:0] DIV_LAST = 8'(FADE_DIV - 1);

    logic [7:0] div_cnt;
    logic [7:0] div_n;
    logic [3:0] level_n;
    state_t     state_n;

    always_comb begin
        state_n = state;
        level_n = level;
        div_n   = div_cnt;
        case (state)
            ST_OFF: begin
                if (target != 4'd0) begin
                    state_n = ST_RAMP_UP;
                    div_n   = 8'd0;
                end
            end
            ST_STEADY: begin
                if (target > level) begin
                    state_n = ST_RAMP_UP;
                    div_n   = 8'd0;
                end else if (target < level) begin
                    state_n = ST_RAMP_DN;
                    div_n   = 8'd0;
                end
            end
            ST_RAMP_UP: begin
                if (target == level) begin
                    state_n = (target != 4'd0) ? ST_STEADY : ST_OFF;
                end else if (target < level) begin
                    state_n = ST_RAMP_DN;
                    div_n   = 8'd0;
                end else if (div_cnt == DIV_LAST) begin
                    level_n = (level == LVL_MAX) ? level : level + 4'd1;
                    div_n   = 8'd0;
                end else begin
                    div_n   = div_cnt + 8'd1;
                end
            end
            ST_RAMP_DN: begin
                if (target == level) begin
                    state_n = (target != 4'd0) ? ST_STEADY : ST_OFF;
                end else if (target > level) begin
                    state_n = ST_RAMP_UP;
                    div_n   = 8'd0;
                end else if (div_cnt == DIV_LAST) begin
                    level_n = (level == 4'd0) ? level : level - 4'd1;
                    div_n   = 8'd0;
                end else begin
                    div_n   = div_cnt + 8'd1;
                end
            end
            default: begin
                state_n = ST_OFF;
                level_n = 4'd0;
                div_n   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_OFF;
            level   <= 4'd0;
            div_cnt <= 8'd0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            level   <= level_n;
            div_cnt <= div_n;
            busy    <= (state_n == ST_RAMP_UP) || (state_n == ST_RAMP_DN);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OFF;
            level <= 4'd0;
        end else begin
            state <= (target != 4'd0) ? ST_STEADY : ST_OFF;
            level <= target;
        end
    end

    // Ramp states are never entered in this build, so this is constant 0
    assign busy = (state == ST_RAMP_UP) || (state == ST_RAMP_DN);
`endif

    bulb_pwm u_pwm (
        .clk   (clk),
        .rst   (rst),
        .level (level),
        .color (in_q.color),
        .pwm_r (pwm_r),
        .pwm_g (pwm_g),
        .pwm_b (pwm_b)
    );

endmodule

`default_nettype wire
